object_renderer: RTL
====================

# object_renderer

Parametrised multi-object pixel colouriser for the VGA output path, replacing the single hard-coded paddle colouriser. It takes the free-running h/v counters from the sync generator and compares each pixel against `NUM_OBJ` programmable rectangles, such as paddles, ball and score bars. It emits registered RGB with fixed two-cycle latency. Object geometry and colour are written through a shadow register port and committed atomically at frame start, so game logic can update positions at any time without tearing.

## Interface
Parameters:
- `NUM_OBJ`, 4: number of rectangles; index 0 has highest priority.
- `CW`, 10: width of counters and geometry fields.
- `COLOR_W`, 8: bits per colour channel.
- `H_BLANK`, 96: pixels with `h_counter <= H_BLANK` are blanked.
- `V_BLANK`, 2: lines with `v_counter <= V_BLANK` are blanked.

Ports:
- `clk`  in  1  pixel clock; counters advance once per cycle.
- `reset`  in  1  asynchronous, active-high reset.
- `h_counter`  in  CW  horizontal pixel counter.
- `v_counter`  in  CW  vertical line counter.
- `wr_en`  in  1  shadow-register write strobe.
- `wr_idx`  in  $clog2(NUM_OBJ) (min 1)  object selected for the write.
- `wr_x`, `wr_y`  in  CW each  top-left corner of the rectangle.
- `wr_w`, `wr_h`  in  CW each  width and height in pixels.
- `wr_rgb`  in  3*COLOR_W  object colour, packed {R,G,B}.
- `wr_vis`  in  1  object visible flag.
- `bg_rgb`  in  3*COLOR_W  background colour inside the active area.
- `R`, `G`, `B`  out  COLOR_W each  registered pixel colour.
- `de`  out  1  registered active-area flag.
- `frame_start`  out  1  one-cycle pulse when a commit occurs.

## Operation
- **Shadow bank:** one entry per object holding x, y, w, h, rgb and vis.
  - A write with `wr_en=1` updates entry `wr_idx` on the clock edge.
  - Writes with `wr_idx >= NUM_OBJ` are ignored.
- **Active bank:** the same fields, used for rendering.
  - Commit condition: `h_counter==0 && v_counter==0` sampled at a clock edge.
  - On commit, all shadow entries are copied to the active bank on that edge.
  - `frame_start` is registered and goes high for the following cycle.
- **Write coincident with commit:** the active bank receives the pre-write shadow value. The new value becomes active at the next frame's commit.
- **Hit test for object i:** `vis_i && h>=x_i && h<x_i+w_i && v>=y_i && v<y_i+h_i`.
  - Sums are computed at CW+1 bits, so there is no wrap-around.
  - A rectangle extending past `2^CW-1` is clipped, not wrapped.
  - `w==0` or `h==0` never hits.
- **Priority:** the lowest-index hitting object supplies the colour. If no object hits, `bg_rgb` is used.
- **Blanking:** if `v <= V_BLANK` or `h <= H_BLANK`, the output is RGB=0 and `de=0`. Otherwise `de=1`.
- **Pipeline:**
  - Stage 1 registers the per-object hit vector, the blank flag and a snapshot of the object colours.
  - Stage 2 performs priority select and blanking, and registers R/G/B/`de`.
  - Hit tests always use the active bank as it stood on the edge the pixel was sampled.
- **Reset (asynchronous):**
  - R, G, B = 0; `de=0`; `frame_start=0`.
  - All shadow and active fields = 0, with vis=0. `bg_rgb` is not registered.
  - Pipeline registers are cleared.
- **Reset mid-frame:** rendering resumes with the background only until new writes are committed.

## Timing
- Latency: pixel (h, v) presented at edge n appears on R/G/B/`de` after edge n+2.
- Throughput: one pixel per cycle, with no stalls.
- A commit at edge n affects pixels sampled from edge n+1 onward. The pixel at (0, 0) itself is blanked.
- `frame_start` is high during cycle n+1 after the commit edge n, for exactly one cycle.
- A write at edge n is visible in the shadow bank at n+1. It never affects rendering before the next commit.
- `bg_rgb` is sampled in stage 1, with the same latency as the counters.

## Test plan
- **Reset:** assert `reset` asynchronously mid-cycle → R=G=B=0, `de=0` immediately. After release, a commit, and pixel (200, 100) → output equals `bg_rgb`.
- **Single object:** obj0 = x=300, y=509, w=170, h=16, rgb=FFFFFF, vis=1; commit → (300, 509) and (469, 524) are white; (299, 509), (470, 509) and (300, 525) show background; latency is exactly 2 cycles.
- **Priority:** obj0 red and obj2 blue overlap at (400, 200) → red. Clearing obj0 vis and committing → blue.
- **Blanking:** obj0 covering the full screen → `h_counter` 96 is black with `de=0`; 97 is coloured. `v_counter` 2 is black; 3 is coloured.
- **Commit atomicity:**
  - A write to obj1 mid-frame → no change until after (0, 0), then the change takes effect.
  - A write coincident with the (0, 0) edge → old value rendered for one frame, new value from the following frame.
  - `frame_start` pulses once per frame.
- **Edge cases:**
  - x=1000, w=100 with CW=10 → hits h 1000..1023 only, with no wrap hit at h 0..75.
  - w=0 → never hits.
  - `wr_idx` = NUM_OBJ with `wr_en=1` → no state change.

Source files
------------

// File: rtl/object_renderer.sv
// Multi-object rectangle colouriser for the VGA path: a shadow bank of rectangles is committed
// to an active bank at (0,0), then hit-tested, prioritised and blanked over two register stages.
module object_renderer #(
   parameter int unsigned NUM_OBJ = 4,
   parameter int unsigned CW      = 10,
   parameter int unsigned COLOR_W = 8,
   parameter int unsigned H_BLANK = 96,
   parameter int unsigned V_BLANK = 2,
   localparam int unsigned IW     = (NUM_OBJ > 1) ? $clog2(NUM_OBJ) : 1
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic [CW-1:0]          h_counter,
   input  logic [CW-1:0]          v_counter,
   input  logic                   wr_en,
   input  logic [IW-1:0]          wr_idx,
   input  logic [CW-1:0]          wr_x,
   input  logic [CW-1:0]          wr_y,
   input  logic [CW-1:0]          wr_w,
   input  logic [CW-1:0]          wr_h,
   input  logic [3*COLOR_W-1:0]   wr_rgb,
   input  logic                   wr_vis,
   input  logic [3*COLOR_W-1:0]   bg_rgb,
   output logic [COLOR_W-1:0]     R,
   output logic [COLOR_W-1:0]     G,
   output logic [COLOR_W-1:0]     B,
   output logic                   de,
   output logic                   frame_start
);

   typedef struct packed {
      logic                 vis;
      logic [CW-1:0]        x;
      logic [CW-1:0]        y;
      logic [CW-1:0]        w;
      logic [CW-1:0]        h;
      logic [3*COLOR_W-1:0] rgb;
   } obj_t;

   obj_t                 r_shadow [NUM_OBJ];
   obj_t                 r_act    [NUM_OBJ];
   logic [3*COLOR_W-1:0] r_col    [NUM_OBJ];
   logic [NUM_OBJ-1:0]   r_hit;
   logic                 r_blank;
   logic [3*COLOR_W-1:0] r_bg;
   logic [COLOR_W-1:0]   r_r;
   logic [COLOR_W-1:0]   r_g;
   logic [COLOR_W-1:0]   r_b;
   logic                 r_de;
   logic                 r_fs;

   obj_t                 w_wr;
   logic                 w_commit;
   logic                 w_blank;
   logic [NUM_OBJ-1:0]   w_hit;
   logic [3*COLOR_W-1:0] w_sel;

   assign w_wr     = '{vis: wr_vis, x: wr_x, y: wr_y, w: wr_w, h: wr_h, rgb: wr_rgb};
   assign w_commit = (h_counter == '0) && (v_counter == '0);
   assign w_blank  = (32'(v_counter) <= V_BLANK) || (32'(h_counter) <= H_BLANK);

   // Out-of-range wr_idx matches no entry, so such writes fall away naturally.
   for (genvar gi = 0; gi < NUM_OBJ; gi++) begin : g_obj
      always_ff @(posedge clk or posedge reset) begin
         if (reset) begin
            r_shadow[gi] <= '0;
            r_act[gi]    <= '0;
            r_col[gi]    <= '0;
         end else begin
            if (wr_en && (wr_idx == IW'(gi))) begin
               r_shadow[gi] <= w_wr;
            end
            if (w_commit) begin
               r_act[gi] <= r_shadow[gi];
            end
            r_col[gi] <= r_act[gi].rgb;
         end
      end
   end

   // Bounds are widened by one bit so rectangles near 2^CW-1 clip instead of wrapping.
   always_comb begin
      w_hit = '0;
      for (int i = 0; i < int'(NUM_OBJ); i++) begin
         w_hit[i] = r_act[i].vis
                  && ({1'b0, h_counter} >= {1'b0, r_act[i].x})
                  && ({1'b0, h_counter} <  ({1'b0, r_act[i].x} + {1'b0, r_act[i].w}))
                  && ({1'b0, v_counter} >= {1'b0, r_act[i].y})
                  && ({1'b0, v_counter} <  ({1'b0, r_act[i].y} + {1'b0, r_act[i].h}));
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_hit   <= '0;
         r_blank <= 1'b1;
         r_bg    <= '0;
         r_fs    <= 1'b0;
      end else begin
         r_hit   <= w_hit;
         r_blank <= w_blank;
         r_bg    <= bg_rgb;
         r_fs    <= w_commit;
      end
   end

   // Walk from lowest priority upward so index 0 wins.
   always_comb begin
      w_sel = r_bg;
      for (int i = int'(NUM_OBJ) - 1; i >= 0; i--) begin
         if (r_hit[i]) begin
            w_sel = r_col[i];
         end
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_r  <= '0;
         r_g  <= '0;
         r_b  <= '0;
         r_de <= 1'b0;
      end else if (r_blank) begin
         r_r  <= '0;
         r_g  <= '0;
         r_b  <= '0;
         r_de <= 1'b0;
      end else begin
         r_r  <= w_sel[3*COLOR_W-1:2*COLOR_W];
         r_g  <= w_sel[2*COLOR_W-1:COLOR_W];
         r_b  <= w_sel[COLOR_W-1:0];
         r_de <= 1'b1;
      end
   end

   assign R           = r_r;
   assign G           = r_g;
   assign B           = r_b;
   assign de          = r_de;
   assign frame_start = r_fs;

endmodule
